result_collector: RTL and testbench
===================================

Name: result_collector

Overview:
- Receiving end of the systolic array datapath: captures skewed per-column results from the array's bottom edge.
- Deskews the columns into aligned rows and stores rows in a circular row FIFO.
- Drains rows element-by-element over a valid/ready stream.
- Driven by the same 2-bit state bus as the array input buffers.

Parameters:
- ARR_SIZE, 4, number of array columns (elements per row)
- DATA_W, 16, result element width
- ROW_DEPTH, ARR_SIZE*2, FIFO capacity in rows
- ADDR_WIDTH, $clog2(ROW_DEPTH), row pointer width

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  reset, asynchronous, active-low
- state  input  2  00 idle/clear, 01 capture, 10 drain, 11 hold
- col_in  input  ARR_SIZE*DATA_W  column k at bits [k*DATA_W +: DATA_W]; column k is valid k cycles after column 0
- in_valid  input  1  qualifies column 0 of a row; sampled only when state==01
- out_data  output  DATA_W  current drain element
- out_valid  output  1  out_data is valid
- out_ready  input  1  consumer accepts the element
- out_last  output  1  out_data is the final element of its row
- count  output  ADDR_WIDTH+1  rows stored
- full  output  1  count==ROW_DEPTH
- empty  output  1  count==0
- overflow  output  1  sticky; an aligned row was dropped

Behaviour:
- Reset (rst low, asynchronous): clear head, tail, count, col_idx, all deskew registers, out_data, out_valid, out_last and overflow to 0. Leave FIFO storage uninitialised.
- Deskew:
  - Delay column k by ARR_SIZE-1-k registers.
  - Delay in_valid & (state==01) by ARR_SIZE-1 registers to form row_valid.
  - Deskew registers shift every cycle regardless of state, so rows started in capture complete after state changes.
- Row write:
  - When row_valid=1 and the FIFO is not full, write the aligned row at tail, then tail=(tail+1) mod ROW_DEPTH and count+1.
  - Latency: column 0 presented at cycle t is visible in count at cycle t+ARR_SIZE.
- Overflow: if row_valid=1 and full with no pop in the same cycle, drop the row and set overflow. Clear overflow only by reset or state==00.
- Drain (state==10):
  - out_valid=!empty.
  - out_data=row[head][col_idx].
  - out_last=(col_idx==ARR_SIZE-1).
  - On out_valid&&out_ready: col_idx+1. At the last element, col_idx=0, head=(head+1) mod ROW_DEPTH, count-1.
  - out_data and out_last hold stable while out_valid&&!out_ready.
- Simultaneous events:
  - A pop and a row write in the same cycle leave count unchanged.
  - A write while full that coincides with the last-element pop is accepted, with no overflow.
- States other than drain:
  - 01 and 11: out_valid=0; col_idx, head and FIFO contents retained. A partially drained row resumes at the same col_idx in the next drain.
  - 00: out_valid=0, out_data=0, out_last=0, overflow cleared; FIFO contents and pointers retained.
- Wrap-around: head and tail wrap modulo ROW_DEPTH. count ranges 0..ROW_DEPTH.
- Reset asserted mid-drain or mid-skew: everything returns to the reset values immediately; in-flight rows are lost.

Optional Feature:
- COLLECTOR_COL_REVERSE_EN defined: the drain order within a row is column ARR_SIZE-1 down to 0. out_data=row[head][ARR_SIZE-1-col_idx]; out_last stays asserted on the final element emitted.
- Undefined: the drain order is column 0 to ARR_SIZE-1.
- All other behaviour is identical.

Test Plan:
- Skewed capture (ARR_SIZE=4): present row 0 with col k=16'h0100+k, column k at cycle t+k, state=01 → count=1 at t+4. Drain with out_ready=1 → out_data 0100,0101,0102,0103; out_last only on 0103.
- Back-to-back capture: 8 consecutive rows r with col k=16'h0r0k → full=1, overflow=0. A 9th row → overflow=1, count=8. Draining all 32 elements yields rows 0..7 in order; empty=1 at the end.
- Backpressure: drain with out_ready toggling 1,0,0,1 → out_data unchanged while out_valid&&!out_ready; no element skipped or duplicated.
- Mid-row state change: drain 2 elements of row 0103-style data, then state=11 for 3 cycles, then state=10 → resumes at 0102; count decrements only after 0103.
- Clear and reset: state=00 → out_valid=0, out_data=0, overflow=0, count retained. Pulse rst low mid-drain → count=0, empty=1, out_valid=0 asynchronously.
- COLLECTOR_COL_REVERSE_EN defined: the row from the first scenario drains as 0103,0102,0101,0100; out_last on 0100.

Source files
------------

// File: rtl/result_collector.sv
// result_collector: deskews column results from the array bottom edge into rows,
// buffers them in a circular row FIFO and drains them element-by-element.
// Build option: define COLLECTOR_COL_REVERSE_EN to drain each row from the last column down to 0.
`default_nettype none

module result_collector #(
  parameter int ARR_SIZE   = 4,
  parameter int DATA_W     = 16,
  parameter int ROW_DEPTH  = ARR_SIZE * 2,
  parameter int ADDR_WIDTH = $clog2(ROW_DEPTH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [1:0]                   state,
  input  logic [ARR_SIZE*DATA_W-1:0]   col_in,
  input  logic                         in_valid,
  output logic [DATA_W-1:0]            out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_last,
  output logic [ADDR_WIDTH:0]          count,
  output logic                         full,
  output logic                         empty,
  output logic                         overflow
);

  localparam logic [1:0] ST_IDLE    = 2'b00;
  localparam logic [1:0] ST_CAPTURE = 2'b01;
  localparam logic [1:0] ST_DRAIN   = 2'b10;

  localparam int                  COL_W     = (ARR_SIZE > 1) ? $clog2(ARR_SIZE) : 1;
  localparam logic [COL_W-1:0]    LAST_COL  = COL_W'(ARR_SIZE - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(ROW_DEPTH - 1);
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH+1)'(ROW_DEPTH);

  logic [ARR_SIZE*DATA_W-1:0] aligned;
  logic                       row_valid;
  logic                       capture_valid;

  logic [ARR_SIZE*DATA_W-1:0] mem [ROW_DEPTH];
  logic [ADDR_WIDTH-1:0]      head;
  logic [ADDR_WIDTH-1:0]      tail;
  logic [COL_W-1:0]           col_idx;
  logic [COL_W-1:0]           col_sel;
  logic [ARR_SIZE*DATA_W-1:0] head_row;

  logic last_col;
  logic accept;
  logic pop;
  logic push;
  logic drop;

  assign capture_valid = in_valid && (state == ST_CAPTURE);

  // Column k arrives k cycles late, so it is delayed ARR_SIZE-1-k cycles to line up.
  for (genvar k = 0; k < ARR_SIZE; k++) begin : g_col
    localparam int DEPTH = ARR_SIZE - 1 - k;
    if (DEPTH == 0) begin : g_direct
      assign aligned[k*DATA_W +: DATA_W] = col_in[k*DATA_W +: DATA_W];
    end else begin : g_delay
      logic [DATA_W-1:0] pipe [DEPTH];
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
        end else begin
          pipe[0] <= col_in[k*DATA_W +: DATA_W];
          for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
        end
      end
      assign aligned[k*DATA_W +: DATA_W] = pipe[DEPTH-1];
    end
  end

  if (ARR_SIZE > 1) begin : g_valid_delay
    logic [ARR_SIZE-2:0] vpipe;
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        vpipe <= '0;
      end else begin
        vpipe[0] <= capture_valid;
        for (int i = 1; i < ARR_SIZE - 1; i++) vpipe[i] <= vpipe[i-1];
      end
    end
    assign row_valid = vpipe[ARR_SIZE-2];
  end else begin : g_valid_direct
    assign row_valid = capture_valid;
  end

  assign empty     = (count == '0);
  assign full      = (count == DEPTH_CNT);
  assign out_valid = (state == ST_DRAIN) && !empty;
  assign last_col  = (col_idx == LAST_COL);
  assign out_last  = out_valid && last_col;
  assign accept    = out_valid && out_ready;
  assign pop       = accept && last_col;
  // A full FIFO still accepts a row when the head row leaves in the same cycle.
  assign push      = row_valid && (!full || pop);
  assign drop      = row_valid && full && !pop;

`ifdef COLLECTOR_COL_REVERSE_EN
  assign col_sel = LAST_COL - col_idx;
`else
  assign col_sel = col_idx;
`endif

  assign head_row = mem[head];

  always_comb begin
    out_data = '0;
    if (out_valid) begin
      out_data = head_row[int'(col_sel)*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[tail] <= aligned;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      col_idx <= '0;
    end else begin
      if (accept) begin
        col_idx <= last_col ? '0 : col_idx + 1'b1;
      end
      if (pop) begin
        head <= (head == LAST_PTR) ? '0 : head + 1'b1;
      end
      if (push) begin
        tail <= (tail == LAST_PTR) ? '0 : tail + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow <= 1'b0;
    end else if (state == ST_IDLE) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_result_collector.sv
// tb_result_collector: scoreboard bench for result_collector (skewed capture, drain, backpressure, clear, reset).
`default_nettype none

module tb_result_collector;

  localparam int ARR_SIZE   = 4;
  localparam int DATA_W     = 16;
  localparam int ROW_DEPTH  = 8;
  localparam int ADDR_WIDTH = 3;

  logic                       clk = 1'b0;
  logic                       rst;
  logic [1:0]                 state;
  logic [ARR_SIZE*DATA_W-1:0] col_in;
  logic                       in_valid;
  logic [DATA_W-1:0]          out_data;
  logic                       out_valid;
  logic                       out_ready;
  logic                       out_last;
  logic [ADDR_WIDTH:0]        count;
  logic                       full;
  logic                       empty;
  logic                       overflow;

  result_collector #(
    .ARR_SIZE  (ARR_SIZE),
    .DATA_W    (DATA_W),
    .ROW_DEPTH (ROW_DEPTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .state    (state),
    .col_in   (col_in),
    .in_valid (in_valid),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last (out_last),
    .count    (count),
    .full     (full),
    .empty    (empty),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   model_count = 0;
  logic model_ovf = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] elem(input int r, input int k);
    return DATA_W'((r << 8) | k);
  endfunction

  task automatic push_row(input int r);
    exp_t e;
    if (model_count < ROW_DEPTH) begin
      for (int i = 0; i < ARR_SIZE; i++) begin
`ifdef COLLECTOR_COL_REVERSE_EN
        e.data = elem(r, ARR_SIZE - 1 - i);
`else
        e.data = elem(r, i);
`endif
        e.last = (i == ARR_SIZE - 1);
        sb.push_back(e);
      end
      model_count++;
    end else begin
      model_ovf = 1'b1;
    end
  endtask

  // Drives n rows back to back with column k of row r presented k cycles after its column 0.
  task automatic capture(input int first_row, input int n);
    int pre;
    pre = model_count;
    for (int c = 0; c < n + ARR_SIZE - 1; c++) begin
      @(negedge clk);
      state    = 2'b01;
      in_valid = (c < n);
      for (int k = 0; k < ARR_SIZE; k++) begin
        col_in[k*DATA_W +: DATA_W] = (c - k >= 0 && c - k < n) ? elem(first_row + c - k, k) : 16'hDEAD;
      end
      if (c < n) push_row(first_row + c);
      if (n == 1 && c == ARR_SIZE - 1) begin
        #1 check("latency_pre", count, pre);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    col_in   = '0;
    state    = 2'b11;
  endtask

  // Drains n elements; bp selects the ready pattern 1,0,0,1 repeating.
  task automatic drain(input int n, input bit bp);
    int got = 0;
    int cyc = 0;
    while (got < n && cyc < 400) begin
      @(negedge clk);
      state     = 2'b10;
      out_ready = bp ? ((cyc % 4) == 0 || (cyc % 4) == 3) : 1'b1;
      #1;
      check("count", count, model_count);
      if (out_valid) begin
        if (sb.size() == 0) begin
          check("spurious_valid", {31'b0, out_valid}, 32'd0);
        end else begin
          check("out_data", out_data, sb[0].data);
          check("out_last", out_last, sb[0].last);
          if (out_ready) begin
            if (sb[0].last) model_count--;
            void'(sb.pop_front());
            got++;
          end
        end
      end
      cyc++;
    end
    if (got < n) check("drain_timeout", got, n);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b0;
    state     = 2'b00;
    col_in    = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_ovf", overflow, 0);
    @(negedge clk);
    rst = 1'b1;

    // Single skewed row, ready held high.
    capture(1, 1);
    #1 check("s1_count", count, 1);
    drain(4, 1'b0);
    #1 check("s1_empty", empty, 1);

    // Fill to capacity, then one extra row is dropped.
    capture(0, 8);
    #1;
    check("s2_full", full, 1);
    check("s2_ovf0", overflow, 0);
    check("s2_count", count, 8);
    capture(8, 1);
    #1;
    check("s2_ovf1", overflow, model_ovf);
    check("s2_count9", count, 8);
    drain(32, 1'b0);
    #1 check("s2_empty", empty, 1);

    // Backpressure.
    capture(32, 2);
    drain(8, 1'b1);
    #1 check("bp_empty", empty, 1);

    // Partial drain, hold, resume.
    capture(1, 1);
    drain(2, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      state = 2'b11;
      #1;
      check("hold_valid", out_valid, 0);
      check("hold_count", count, 1);
    end
    drain(2, 1'b0);
    #1 check("resume_empty", empty, 1);

    // Clear state keeps stored rows but drops outputs and the sticky flag.
    capture(48, 1);
    #1 check("pre_clr_ovf", overflow, 1);
    @(negedge clk);
    state = 2'b00;
    #1;
    check("clr_valid", out_valid, 0);
    check("clr_data", out_data, 0);
    check("clr_last", out_last, 0);
    @(negedge clk);
    #1;
    model_ovf = 1'b0;
    check("clr_ovf", overflow, model_ovf);
    check("clr_count", count, model_count);
    drain(4, 1'b0);

    // Asynchronous reset in the middle of a drain.
    capture(64, 2);
    drain(3, 1'b0);
    @(negedge clk);
    state     = 2'b10;
    out_ready = 1'b1;
    #2 rst = 1'b0;
    #1;
    check("arst_count", count, 0);
    check("arst_empty", empty, 1);
    check("arst_valid", out_valid, 0);
    sb.delete();
    model_count = 0;
    @(negedge clk);
    out_ready = 1'b0;
    rst = 1'b1;

    capture(80, 1);
    drain(4, 1'b0);
    #1 check("final_empty", empty, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
